// File: rtl/score_bcd_pkg.sv
// Shared definitions for the game score counter: run-state encoding and BCD digit constants.
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/score_bcd_if.sv
// Game-control and score-display signals of the score counter.
// master: game control / display side, slave: score_bcd.
interface score_bcd_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    frame_tick;
  logic                    game_start;
  logic                    game_over;
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    running;
  logic                    milestone;
  logic                    saturated;
  logic [4*NUM_DIGITS-1:0] hi_digits;
  logic                    new_record;

  modport master (
    output frame_tick, game_start, game_over,
    input  digits, running, milestone, saturated, hi_digits, new_record
  );

  modport slave (
    input  frame_tick, game_start, game_over,
    output digits, running, milestone, saturated, hi_digits, new_record
  );
endinterface

// File: rtl/score_bcd_digit.sv
// One BCD digit of the score chain. Counts 0..9; a 9 receiving a carry rolls
// to 0 and passes the carry on. carry_out is combinational so the whole chain
// resolves in a single cycle.
module bcd_digit
  import dino_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic             carry_in,
  output logic [BCD_W-1:0] q,
  output logic             carry_out
);

  assign carry_out = (q == BCD_MAX) && carry_in;

  // digit register: clear on run start, step when the chain carries into it
  always_ff @(posedge clk) begin
    if (reset)                q <= '0;
    else if (clr)             q <= '0;
    else if (inc && carry_in) q <= (q == BCD_MAX) ? '0 : q + BCD_W'(1);
  end

endmodule

// File: rtl/score_bcd.sv
// Game score counter: counts frame ticks during a run and presents the score
// as packed BCD (digit 0 = units in [3:0]). Saturates at all-9s.
// Optional build macro HIGH_SCORE_EN adds the high-score register and new_record flag.
//
// state | meaning
// IDLE  | after reset, waiting for the first game_start
// RUN   | game running, frame ticks accumulate score
// OVER  | collision seen, score frozen until next game_start
module score_bcd
  import dino_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCORE_DIV  = 6
) (
  input  logic        clk,
  input  logic        reset,
  score_bcd_if.slave  bus
);

  localparam int PRE_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;

  state_t                  state, state_nxt;
  logic [PRE_W-1:0]        prescaler;
  logic                    start_run, end_run, tick_due, score_inc, all_nine;
  logic                    saturated_q, milestone_q;
  logic [NUM_DIGITS:0]     carry;
  logic [4*NUM_DIGITS-1:0] score;

  // the chain always "wants" to add one; inc gates whether the digits take it
  assign carry[0]  = 1'b1;
  assign all_nine  = &carry[NUM_DIGITS:1];
  assign tick_due  = (state == RUN) && bus.frame_tick && !bus.game_over &&
                     (prescaler == PRE_W'(SCORE_DIV - 1));
  assign score_inc = tick_due && !all_nine;

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
        .clk       (clk),
        .reset     (reset),
        .clr       (start_run),
        .inc       (score_inc),
        .carry_in  (carry[g]),
        .q         (score[g*BCD_W +: BCD_W]),
        .carry_out (carry[g+1])
      );
    end
  endgenerate

  // run-state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state; game_start is ignored in RUN, game_over outside RUN
  always_comb begin
    state_nxt = state;
    start_run = 1'b0;
    end_run   = 1'b0;
    case (state)
      IDLE, OVER: if (bus.game_start) begin
        state_nxt = RUN;
        start_run = 1'b1;
      end
      RUN: if (bus.game_over) begin
        state_nxt = OVER;
        end_run   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // frame prescaler; frozen on the cycle game_over ends the run
  always_ff @(posedge clk) begin
    if (reset || start_run)
      prescaler <= '0;
    else if ((state == RUN) && bus.frame_tick && !bus.game_over)
      prescaler <= tick_due ? '0 : prescaler + PRE_W'(1);
  end

  // saturated latches when an increment is refused at all-9s
  always_ff @(posedge clk) begin
    if (reset || start_run)      saturated_q <= 1'b0;
    else if (tick_due && all_nine) saturated_q <= 1'b1;
  end

  // milestone: an increment that rolls both units and tens over lands on a
  // nonzero multiple of 100 (a clear never goes through this path)
  always_ff @(posedge clk) begin
    if (reset) milestone_q <= 1'b0;
    else       milestone_q <= score_inc && carry[2];
  end

`ifdef HIGH_SCORE_EN
  logic [4*NUM_DIGITS-1:0] hi_q;
  logic                    new_record_q;

  // packed BCD orders like an unsigned integer, so a plain compare suffices
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q         <= '0;
      new_record_q <= 1'b0;
    end else if (start_run) begin
      new_record_q <= 1'b0;
    end else if (end_run) begin
      new_record_q <= (score > hi_q);
      if (score > hi_q) hi_q <= score;
    end
  end

  assign bus.hi_digits  = hi_q;
  assign bus.new_record = new_record_q;
`else
  assign bus.hi_digits  = '0;
  assign bus.new_record = 1'b0;
`endif

  assign bus.digits    = score;
  assign bus.running   = (state == RUN);
  assign bus.milestone = milestone_q;
  assign bus.saturated = saturated_q;

endmodule

// File: tb/tb_score_bcd.sv
// Self-checking bench for score_bcd. Reference model keeps the score as a
// plain integer and converts to BCD only for comparison.
module tb_score_bcd;

  localparam int NUM_DIGITS = 4;
  localparam int SCORE_DIV  = 6;
  localparam int MAX_SCORE  = 9999;
`ifdef HIGH_SCORE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  logic clk;
  logic reset;
  int   compared = 0;
  int   mismatched = 0;

  // model state: 0 idle, 1 running, 2 over
  int   m_state = 0;
  int   m_score = 0;
  int   m_pre   = 0;
  int   m_hi    = 0;
  bit   m_sat   = 0;
  bit   m_ms    = 0;
  bit   m_nr    = 0;

  score_bcd_if #(.NUM_DIGITS(NUM_DIGITS)) sif ();

  score_bcd #(.NUM_DIGITS(NUM_DIGITS), .SCORE_DIV(SCORE_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic void model_update(input bit ft, input bit gs, input bit go, input bit rst);
    m_ms = 0;
    if (rst) begin
      m_state = 0; m_score = 0; m_pre = 0; m_sat = 0; m_hi = 0; m_nr = 0;
      return;
    end
    case (m_state)
      0, 2: if (gs) begin
        m_state = 1; m_score = 0; m_pre = 0; m_sat = 0; m_nr = 0;
      end
      1: begin
        if (go) begin
          m_state = 2;
          if (HS && m_score > m_hi) begin
            m_hi = m_score;
            m_nr = 1;
          end
        end else if (ft) begin
          m_pre++;
          if (m_pre == SCORE_DIV) begin
            m_pre = 0;
            if (m_score == MAX_SCORE) m_sat = 1;
            else begin
              m_score++;
              if (m_score % 100 == 0) m_ms = 1;
            end
          end
        end
      end
      default: m_state = 0;
    endcase
  endfunction

  task automatic step(input bit ft, input bit gs, input bit go, input bit rst);
    sif.frame_tick = ft;
    sif.game_start = gs;
    sif.game_over  = go;
    reset          = rst;
    @(posedge clk);
    model_update(ft, gs, go, rst);
    #1;
    sif.frame_tick = 1'b0;
    sif.game_start = 1'b0;
    sif.game_over  = 1'b0;
    reset          = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    compared++;
    if (sif.digits !== 16'h0000) begin mismatched++; $display("FAIL reset_digits got %h want 0000", sif.digits); end
    compared++;
    if (sif.running !== 1'b0) begin mismatched++; $display("FAIL reset_running got %b want 0", sif.running); end
    compared++;
    if (sif.milestone !== 1'b0 || sif.saturated !== 1'b0) begin
      mismatched++; $display("FAIL reset_flags got ms=%b sat=%b want 0 0", sif.milestone, sif.saturated);
    end
    compared++;
    if (sif.hi_digits !== 16'h0000 || sif.new_record !== 1'b0) begin
      mismatched++; $display("FAIL reset_hi got %h nr=%b want 0000 0", sif.hi_digits, sif.new_record);
    end
  endtask

  task automatic test_count();
    step(0, 1, 0, 0);
    compared++;
    if (sif.running !== 1'b1 || sif.digits !== 16'h0000) begin
      mismatched++; $display("FAIL start got run=%b digits=%h want 1 0000", sif.running, sif.digits);
    end
    ticks(5);
    compared++;
    if (sif.digits !== 16'h0000) begin mismatched++; $display("FAIL five_ticks got %h want 0000", sif.digits); end
    ticks(1);
    compared++;
    if (sif.digits !== 16'h0001) begin mismatched++; $display("FAIL six_ticks got %h want 0001", sif.digits); end
    ticks(5);
    compared++;
    if (sif.digits !== 16'h0001) begin mismatched++; $display("FAIL prescaler_wrap got %h want 0001", sif.digits); end
    ticks(1);
    compared++;
    if (sif.digits !== 16'h0002 || sif.digits !== to_bcd(m_score)) begin
      mismatched++; $display("FAIL second_point got %h want 0002", sif.digits);
    end
  endtask

  task automatic test_milestone();
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    for (int i = 0; i < 99 * SCORE_DIV; i++) begin
      step(1, 0, 0, 0);
      compared++;
      if (sif.milestone !== 1'b0) begin mismatched++; $display("FAIL early_milestone got 1 want 0 at %h", sif.digits); end
    end
    compared++;
    if (sif.digits !== 16'h0099) begin mismatched++; $display("FAIL preload_99 got %h want 0099", sif.digits); end
    ticks(6);
    compared++;
    if (sif.digits !== 16'h0100 || sif.milestone !== 1'b1) begin
      mismatched++; $display("FAIL milestone_100 got %h ms=%b want 0100 1", sif.digits, sif.milestone);
    end
    step(0, 0, 0, 0);
    compared++;
    if (sif.milestone !== 1'b0 || sif.digits !== 16'h0100) begin
      mismatched++; $display("FAIL milestone_width got %h ms=%b want 0100 0", sif.digits, sif.milestone);
    end
  endtask

  task automatic test_game_over_tie();
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    ticks(41 * SCORE_DIV + 5);
    step(1, 0, 1, 0);
    compared++;
    if (sif.digits !== 16'h0041 || sif.running !== 1'b0) begin
      mismatched++; $display("FAIL over_wins got %h run=%b want 0041 0", sif.digits, sif.running);
    end
    ticks(12);
    compared++;
    if (sif.digits !== 16'h0041) begin mismatched++; $display("FAIL over_frozen got %h want 0041", sif.digits); end
    step(0, 0, 1, 0);
    compared++;
    if (sif.running !== 1'b0 || sif.digits !== to_bcd(m_score)) begin
      mismatched++; $display("FAIL over_again got run=%b %h want 0 0041", sif.running, sif.digits);
    end
  endtask

  task automatic test_high_score();
    int          runs[3]   = '{120, 120, 200};
    logic [15:0] hi_exp[3] = '{16'h0120, 16'h0120, 16'h0200};
    bit          nr_exp[3] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] h;
    bit          n;
    step(0, 0, 0, 1);
    for (int r = 0; r < 3; r++) begin
      step(0, 1, 0, 0);
      compared++;
      if (sif.new_record !== 1'b0) begin mismatched++; $display("FAIL nr_clear run%0d got 1 want 0", r); end
      ticks(runs[r] * SCORE_DIV);
      step(0, 0, 1, 0);
      h = HS ? hi_exp[r] : 16'h0000;
      n = HS ? nr_exp[r] : 1'b0;
      compared++;
      if (sif.hi_digits !== h || sif.new_record !== n) begin
        mismatched++; $display("FAIL high_score run%0d got %h nr=%b want %h %b", r, sif.hi_digits, sif.new_record, h, n);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    step(0, 1, 0, 0);
    for (int i = 0; i < 37; i++) begin
      ticks(SCORE_DIV);
      if (i % 9 == 4) step(0, 1, 0, 0);
    end
    compared++;
    if (sif.digits !== 16'h0037 || sif.running !== 1'b1) begin
      mismatched++; $display("FAIL start_in_run got %h run=%b want 0037 1", sif.digits, sif.running);
    end
    step(1, 0, 0, 1);
    compared++;
    if (sif.digits !== 16'h0000 || sif.running !== 1'b0 || sif.hi_digits !== 16'h0000 || sif.new_record !== 1'b0) begin
      mismatched++; $display("FAIL mid_reset got %h run=%b hi=%h nr=%b want 0000 0 0000 0",
                             sif.digits, sif.running, sif.hi_digits, sif.new_record);
    end
  endtask

  task automatic test_saturation();
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    ticks(MAX_SCORE * SCORE_DIV);
    compared++;
    if (sif.digits !== 16'h9999 || sif.saturated !== 1'b0) begin
      mismatched++; $display("FAIL reach_max got %h sat=%b want 9999 0", sif.digits, sif.saturated);
    end
    for (int i = 0; i < 2 * SCORE_DIV; i++) begin
      step(1, 0, 0, 0);
      compared++;
      if (sif.digits !== 16'h9999 || sif.milestone !== 1'b0) begin
        mismatched++; $display("FAIL sat_hold got %h ms=%b want 9999 0", sif.digits, sif.milestone);
      end
    end
    compared++;
    if (sif.saturated !== 1'b1) begin mismatched++; $display("FAIL saturated got %b want 1", sif.saturated); end
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    compared++;
    if (sif.saturated !== 1'b0 || sif.digits !== 16'h0000) begin
      mismatched++; $display("FAIL sat_clear got %h sat=%b want 0000 0", sif.digits, sif.saturated);
    end
  endtask

  task automatic test_random();
    bit ft, gs, go, rst;
    step(0, 0, 0, 1);
    for (int i = 0; i < 4000; i++) begin
      ft  = ($urandom_range(0, 3) != 0);
      gs  = ($urandom_range(0, 60) == 0);
      go  = ($urandom_range(0, 250) == 0);
      rst = ($urandom_range(0, 1500) == 0);
      step(ft, gs, go, rst);
      compared++;
      if (sif.digits !== to_bcd(m_score)) begin
        mismatched++; $display("FAIL rand_digits cyc %0d got %h want %h", i, sif.digits, to_bcd(m_score));
      end
      compared++;
      if (sif.running !== (m_state == 1) || sif.milestone !== m_ms || sif.saturated !== m_sat) begin
        mismatched++; $display("FAIL rand_flags cyc %0d got run=%b ms=%b sat=%b want %b %b %b",
                               i, sif.running, sif.milestone, sif.saturated, (m_state == 1), m_ms, m_sat);
      end
      compared++;
      if (sif.hi_digits !== to_bcd(m_hi) || sif.new_record !== m_nr) begin
        mismatched++; $display("FAIL rand_hi cyc %0d got %h nr=%b want %h %b",
                               i, sif.hi_digits, sif.new_record, to_bcd(m_hi), m_nr);
      end
    end
  endtask

  initial begin
    reset          = 1'b0;
    sif.frame_tick = 1'b0;
    sif.game_start = 1'b0;
    sif.game_over  = 1'b0;
    #2;
    test_reset();
    test_count();
    test_milestone();
    test_game_over_tie();
    test_high_score();
    test_reset_mid_run();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
